screen_write_queue: RTL and testbench

- Downstream consumer of the transformation pipeline's screen-coordinate output (xAddr, yAddr, Write strobe).
- Clips each coordinate pair to the visible screen, converts in-range pairs to a linear framebuffer address, and buffers pixel writes in a small FIFO.
- Drains the FIFO to framebuffer memory over a valid/ready handshake, so memory stalls never back-pressure the transform pipeline.

---
 rtl/screen_write_queue.sv | 125 ++++++++++++
 tb/tb_screen_write_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_write_queue.sv
// Clips screen coordinates, linearises them to framebuffer addresses and buffers
// pixel writes in a show-ahead FIFO. Optional DROP_COUNT output via `DROP_COUNT_EN.
module screen_write_queue #(
  parameter int COORD_W  = 16,
  parameter int DATA_W   = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int MEM_AW   = 17,
  parameter int DEPTH    = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     ENB,
  input  logic [COORD_W-1:0]       xAddr,
  input  logic [COORD_W-1:0]       yAddr,
  input  logic                     Write,
  input  logic [DATA_W-1:0]        Pixel,
  input  logic                     FLUSH,
  input  logic                     CLR_OVF,
  output logic [MEM_AW-1:0]        MEM_ADDR,
  output logic [DATA_W-1:0]        MEM_DATA,
  output logic                     MEM_WE,
  input  logic                     MEM_READY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW,
  output logic                     BUSY
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]              DROP_COUNT
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic              s1_valid;
  logic [MEM_AW-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;

  logic [PW:0]       wr_ptr, rd_ptr;
  logic [MEM_AW-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [MEM_AW-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  logic sample, in_range, full, pop, do_pop, do_push, ovf_set;

  always_comb begin
    sample   = ENB && Write;
    in_range = (32'(xAddr) < 32'(SCREEN_W)) && (32'(yAddr) < 32'(SCREEN_H));
    LEVEL    = wr_ptr - rd_ptr;
    full     = (LEVEL == (PW+1)'(DEPTH));
    MEM_WE   = (LEVEL != '0);
    pop      = MEM_WE && MEM_READY;
    do_pop   = pop && !FLUSH;
    // a full FIFO still accepts the push when the head leaves in the same cycle
    do_push  = s1_valid && !FLUSH && (!full || pop);
    ovf_set  = s1_valid && !FLUSH && full && !pop;
    BUSY     = s1_valid || MEM_WE;
    MEM_ADDR = MEM_WE ? addr_mem[rd_ptr[PW-1:0]] : last_addr;
    MEM_DATA = MEM_WE ? data_mem[rd_ptr[PW-1:0]] : last_data;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= sample && in_range && !FLUSH;
      if (sample && in_range) begin
        s1_addr <= MEM_AW'(32'(yAddr) * 32'(SCREEN_W) + 32'(xAddr));
        s1_data <= Pixel;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_addr <= addr_mem[rd_ptr[PW-1:0]];
        last_data <= data_mem[rd_ptr[PW-1:0]];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) begin
      addr_mem[wr_ptr[PW-1:0]] <= s1_addr;
      data_mem[wr_ptr[PW-1:0]] <= s1_data;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)       OVERFLOW <= 1'b0;
    else if (ovf_set) OVERFLOW <= 1'b1;
    else if (CLR_OVF) OVERFLOW <= 1'b0;
  end

`ifdef DROP_COUNT_EN
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  always_comb begin
    drop_inc = {1'b0, sample && !in_range} + {1'b0, ovf_set};
    drop_sum = {1'b0, DROP_COUNT} + 17'(drop_inc);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)       DROP_COUNT <= '0;
    else if (CLR_OVF) DROP_COUNT <= '0;
    else              DROP_COUNT <= drop_sum[16] ? '1 : drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_screen_write_queue.sv
// Self-checking bench for screen_write_queue against a queue-based reference model.
module tb_screen_write_queue;

  localparam int DEPTH = 8;
`ifdef DROP_COUNT_EN
  localparam int VW = 48;
`else
  localparam int VW = 32;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET, ENB, Write, FLUSH, CLR_OVF, MEM_READY;
  logic [15:0] xAddr, yAddr;
  logic [7:0]  Pixel;
  logic [16:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        MEM_WE, OVERFLOW, BUSY;
  logic [3:0]  LEVEL;
`ifdef DROP_COUNT_EN
  logic [15:0] DROP_COUNT;
`endif

  screen_write_queue #(
    .COORD_W(16), .DATA_W(8), .SCREEN_W(320), .SCREEN_H(240), .MEM_AW(17), .DEPTH(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .xAddr(xAddr), .yAddr(yAddr),
    .Write(Write), .Pixel(Pixel), .FLUSH(FLUSH), .CLR_OVF(CLR_OVF),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WE(MEM_WE), .MEM_READY(MEM_READY),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .BUSY(BUSY)
`ifdef DROP_COUNT_EN
    , .DROP_COUNT(DROP_COUNT)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t        q[$];
  bit          m_s1v;
  ent_t        m_s1;
  ent_t        m_last;
  bit          m_ovf;
  int unsigned m_drop;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [VW-1:0] dut_vec();
    return {MEM_WE, MEM_ADDR, MEM_DATA, LEVEL, OVERFLOW, BUSY
`ifdef DROP_COUNT_EN
      , DROP_COUNT
`endif
    };
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic we;
    ent_t h;
    we = (q.size() != 0);
    h  = we ? q[0] : m_last;
    return {we, h.a, h.d, 4'(q.size()), m_ovf, m_s1v || we
`ifdef DROP_COUNT_EN
      , 16'(m_drop)
`endif
    };
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1v = 0; m_s1 = '0; m_last = '0; m_ovf = 0; m_drop = 0;
  endtask

  // Advance the model on the current inputs, then clock the DUT to the next negedge.
  task automatic tick();
    bit pop, clip, ovf_set, inr;
    int unsigned lin;
    if (ARESET) model_reset();
    else begin
      ovf_set = 0;
      inr  = (xAddr < 16'd320) && (yAddr < 16'd240);
      clip = ENB && Write && !inr;
      pop  = (q.size() != 0) && MEM_READY;
      if (FLUSH) q.delete();
      else begin
        if (pop) m_last = q.pop_front();
        if (m_s1v) begin
          if (q.size() < DEPTH) q.push_back(m_s1);
          else ovf_set = 1;
        end
      end
      if (ovf_set) m_ovf = 1;
      else if (CLR_OVF) m_ovf = 0;
      if (CLR_OVF) m_drop = 0;
      else begin
        m_drop = m_drop + 32'(clip) + 32'(ovf_set);
        if (m_drop > 65535) m_drop = 65535;
      end
      m_s1v = !FLUSH && ENB && Write && inr;
      if (ENB && Write && inr) begin
        lin  = 32'(yAddr) * 320 + 32'(xAddr);
        m_s1 = {lin[16:0], Pixel};
      end
    end
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic idle();
    Write = 0; FLUSH = 0; CLR_OVF = 0; ENB = 1;
  endtask

  task automatic wr(input int x, input int y, input logic [7:0] p);
    Write = 1; xAddr = 16'(x); yAddr = 16'(y); Pixel = p;
  endtask

  task automatic test_reset();
    ARESET = 1; MEM_READY = 1; xAddr = '0; yAddr = '0; Pixel = '0;
    idle();
    tick(); tick();
    n_cmp++;
    if ({MEM_WE, LEVEL, OVERFLOW, BUSY, MEM_ADDR, MEM_DATA} !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0", {MEM_WE, LEVEL, OVERFLOW, BUSY, MEM_ADDR, MEM_DATA});
    end
    ARESET = 0;
    tick();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    MEM_READY = 1;
    wr(5, 2, 8'h3C);
    tick();
    idle();
    n_cmp++;
    if ({MEM_WE, BUSY} !== 2'b01) begin
      n_bad++; $display("FAIL single_lat1: got we,busy=%b want 01", {MEM_WE, BUSY});
    end
    tick();
    n_cmp++;
    if ({MEM_WE, MEM_ADDR, MEM_DATA} !== {1'b1, 17'd645, 8'h3C}) begin
      n_bad++; $display("FAIL single_out: got we=%b addr=%0d data=%h want 1/645/3c", MEM_WE, MEM_ADDR, MEM_DATA);
    end
    tick();
    n_cmp++;
    if ({MEM_WE, LEVEL} !== 5'b0) begin
      n_bad++; $display("FAIL single_drain: got we=%b level=%0d want 0/0", MEM_WE, LEVEL);
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL single_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_clip();
    int we_seen;
    we_seen = 0;
    MEM_READY = 1;
    wr(320, 0, 8'h11); tick();
    wr(0, 240, 8'h22); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      if (MEM_WE) we_seen++;
      tick();
    end
    n_cmp++;
    if (we_seen !== 0 || OVERFLOW !== 1'b0) begin
      n_bad++; $display("FAIL clip: got we_cycles=%0d ovf=%b want 0/0", we_seen, OVERFLOW);
    end
`ifdef DROP_COUNT_EN
    n_cmp++;
    if (DROP_COUNT !== 16'd2) begin
      n_bad++; $display("FAIL clip_drops: got %0d want 2", DROP_COUNT);
    end
`endif
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL clip_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    ent_t sent[9];
    int unsigned lin;
    MEM_READY = 0;
    for (int i = 0; i < 9; i++) begin
      wr(i * 3, i + 1, 8'(8'hA0 + i));
      lin = 32'(i + 1) * 320 + 32'(i * 3);
      sent[i] = {lin[16:0], 8'(8'hA0 + i)};
      tick();
    end
    idle();
    tick(); tick();
    n_cmp++;
    if ({LEVEL, OVERFLOW} !== {4'd8, 1'b1}) begin
      n_bad++; $display("FAIL ovf_full: got level=%0d ovf=%b want 8/1", LEVEL, OVERFLOW);
    end
    MEM_READY = 1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({MEM_WE, MEM_ADDR, MEM_DATA} !== {1'b1, sent[i].a, sent[i].d}) begin
        n_bad++; $display("FAIL ovf_order%0d: got we=%b %h/%h want 1 %h/%h",
                          i, MEM_WE, MEM_ADDR, MEM_DATA, sent[i].a, sent[i].d);
      end
      tick();
    end
    n_cmp++;
    if (dut_vec() !== exp_vec() || LEVEL !== 4'd0) begin
      n_bad++; $display("FAIL ovf_drain: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_flush();
    MEM_READY = 0;
    for (int i = 0; i < 5; i++) begin
      wr(10 + i, 20, 8'(i)); tick();
    end
    idle();
    tick(); tick();
    n_cmp++;
    if (LEVEL !== 4'd5) begin
      n_bad++; $display("FAIL flush_pre: got level=%0d want 5", LEVEL);
    end
    FLUSH = 1; tick(); FLUSH = 0;
    n_cmp++;
    if ({LEVEL, MEM_WE, OVERFLOW} !== {4'd0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL flush: got level=%0d we=%b ovf=%b want 0/0/1", LEVEL, MEM_WE, OVERFLOW);
    end
    CLR_OVF = 1; tick(); CLR_OVF = 0;
    n_cmp++;
    if (OVERFLOW !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL clr_ovf: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_full_pushpop();
    MEM_READY = 0;
    for (int i = 0; i < 9; i++) begin
      wr(300 + i, 239, 8'(8'h50 + i)); tick();
    end
    idle();
    MEM_READY = 1;
    tick();
    n_cmp++;
    if ({LEVEL, OVERFLOW} !== {4'd8, 1'b0}) begin
      n_bad++; $display("FAIL pushpop: got level=%0d ovf=%b want 8/0", LEVEL, OVERFLOW);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL pushpop_drain%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    MEM_READY = 0;
    for (int i = 0; i < 3; i++) begin
      wr(i, i, 8'(i)); tick();
    end
    idle();
    tick();
    n_cmp++;
    if (MEM_WE !== 1'b1) begin
      n_bad++; $display("FAIL areset_pre: got we=%b want 1", MEM_WE);
    end
    #1 ARESET = 1;
    #1;
    n_cmp++;
    if ({MEM_WE, LEVEL, BUSY} !== 6'b0) begin
      n_bad++; $display("FAIL areset_async: got we=%b level=%0d busy=%b want 0", MEM_WE, LEVEL, BUSY);
    end
    model_reset();
    tick();
    ARESET = 0;
    MEM_READY = 1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) wr(100 + i, 50, 8'(8'hE0 + i)); else idle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL areset_restart%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ENB       = ($urandom_range(0, 9) != 0);
      Write     = ($urandom_range(0, 3) != 0);
      xAddr     = 16'($urandom_range(0, 340));
      yAddr     = 16'($urandom_range(0, 255));
      Pixel     = 8'($urandom);
      MEM_READY = ($urandom_range(0, 2) != 0);
      FLUSH     = ($urandom_range(0, 49) == 0) && !Write;
      CLR_OVF   = ($urandom_range(0, 29) == 0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    model_reset();
    @(negedge ACLK);
    test_reset();
    test_single();
    test_clip();
    test_overflow();
    test_flush();
    test_full_pushpop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
